// File: rtl/extender_arbiter.sv
// Two-requester arbiter sharing one external SignExtender; IDLE -> EXT -> ACK per operation.
// Define RR_ARB_EN for round-robin contention handling; the default is fixed priority to requester 0.
module extender_arbiter #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             req0,
  input  logic             req1,
  input  logic [IMM_W-1:0] imm0,
  input  logic [IMM_W-1:0] imm1,
  input  logic             sign0,
  input  logic             sign1,
  output logic [IMM_W-1:0] extInp,
  output logic             extSignSig,
  input  logic [OUT_W-1:0] extOut,
  output logic [OUT_W-1:0] result,
  output logic             ack0,
  output logic             ack1,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExt, StAck} state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic [IMM_W-1:0]   inp_q, inp_d;
  logic               sign_q, sign_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               win;

`ifdef RR_ARB_EN
  logic               last_grant_q, last_grant_d;

  // On contention favour whoever was not granted last; otherwise the sole requester wins.
  always_comb begin
    if (req0 && req1) begin
      win = ~last_grant_q;
    end else begin
      win = req1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign win = ~req0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    inp_d    = inp_q;
    sign_d   = sign_q;
    result_d = result_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
`ifdef RR_ARB_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StExt;
          grant_d = win;
          inp_d   = win ? imm1 : imm0;
          sign_d  = win ? sign1 : sign0;
`ifdef RR_ARB_EN
          last_grant_d = win;
`endif
        end
      end
      StExt: begin
        result_d = extOut;
        state_d  = StAck;
      end
      StAck: begin
        // Ack is registered, so the pulse lands in the cycle after leaving ACK.
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      inp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      inp_q    <= inp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign extInp     = inp_q;
  assign extSignSig = sign_q;
  assign result     = result_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign busy       = (state_q != StIdle);

`ifndef SYNTHESIS
  ack_onehot_a: assert property (@(posedge clk) disable iff (!rstN) !(ack0_q && ack1_q));
`endif

endmodule
